// File: rtl/moving_sum_normalizer_if.sv
// Bundle between the moving-sum filter, the normalizer and the lock/PID path.
// Pure wiring, no latency.
// No backpressure: the producer strobes freely and the normalizer absorbs or flags overruns.
interface moving_sum_normalizer_if #(
  parameter int SUM_W = 32,
  parameter int OUT_W = 16
);
  logic signed [SUM_W-1:0] sum_in;
  logic                    sum_in_valid;
  logic        [SUM_W-1:0] n_samples;
  logic                    clear_overrun;
  logic signed [OUT_W-1:0] avg_out;
  logic                    avg_out_valid;
  logic                    busy;
  logic                    overrun;

  modport master (
    output sum_in, sum_in_valid, n_samples, clear_overrun,
    input  avg_out, avg_out_valid, busy, overrun
  );

  modport slave (
    input  sum_in, sum_in_valid, n_samples, clear_overrun,
    output avg_out, avg_out_valid, busy, overrun
  );
endinterface

// File: rtl/moving_sum_normalizer.sv
// Divides the signed moving-window sum by the sample count (restoring divide on magnitudes), saturates to OUT_W.
// Latency: avg_out_valid rises after edge SUM_W+1 counting the sampling edge as edge 0.
// No backpressure: one pending slot absorbs a sum arriving mid-divide; overwriting it sets sticky overrun.
module moving_sum_normalizer #(
  parameter int SUM_W = 32,
  parameter int OUT_W = 16
) (
  input logic                    clk,
  input logic                    rst,
  moving_sum_normalizer_if.slave bus_if
);

  localparam int                      CNT_W    = $clog2(SUM_W);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(SUM_W - 1);
  localparam logic [SUM_W-1:0]        POS_LIM  = SUM_W'((1 << (OUT_W - 1)) - 1);
  localparam logic [SUM_W-1:0]        NEG_LIM  = SUM_W'(1 << (OUT_W - 1));
  localparam logic [OUT_W-1:0]        OUT_MAX  = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0]        OUT_MIN  = {1'b1, {(OUT_W - 1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FINISH} state_t;

  state_t             state_q, state_d;
  logic               pend_vld_q, pend_vld_d;
  logic [SUM_W-1:0]   pend_sum_q, pend_sum_d;
  logic [SUM_W-1:0]   pend_n_q, pend_n_d;
  logic               ovr_q, ovr_d;
  logic               sign_q, sign_d;
  logic [SUM_W-1:0]   mag_q, mag_d;
  logic [SUM_W-1:0]   div_q, div_d;
  logic [SUM_W:0]     rem_q, rem_d;
  logic [SUM_W-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   avg_q, avg_d;
  logic               vld_q, vld_d;

  logic               launch;
  logic               busy_c;
  logic [SUM_W-1:0]   job_sum;
  logic [SUM_W-1:0]   job_n;
  logic [SUM_W:0]     rem_sh;
  logic [OUT_W-1:0]   sat_avg;

  // A job launches from IDLE on a strobe or a waiting pending sum, or straight out of FINISH
  // when something is pending; a pending job always takes priority over the live input.
  always_comb begin
    launch  = ((state_q == S_IDLE) && (bus_if.sum_in_valid || pend_vld_q)) ||
              ((state_q == S_FINISH) && pend_vld_q);
    job_sum = pend_vld_q ? pend_sum_q : bus_if.sum_in;
    job_n   = pend_vld_q ? pend_n_q   : bus_if.n_samples;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: DIV runs SUM_W iterations, FINISH either returns to IDLE or chains the pending job.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (launch) state_d = S_DIV;
      S_DIV:    if (cnt_q == CNT_LAST) state_d = S_FINISH;
      S_FINISH: state_d = launch ? S_DIV : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs: busy follows state; the averaged word and its strobe are registered on leaving FINISH.
  always_comb begin
    busy_c = (state_q != S_IDLE);
    vld_d  = (state_q == S_FINISH);
    avg_d  = (state_q == S_FINISH) ? sat_avg : avg_q;
  end

  // Sign reapplication and clamp; magnitude 2^(OUT_W-1) is still representable when negative.
  always_comb begin
    sat_avg = '0;
    if (sign_q) begin
      if (quo_q >= NEG_LIM) sat_avg = OUT_MIN;
      else                  sat_avg = ~quo_q[OUT_W-1:0] + OUT_W'(1);
    end else begin
      if (quo_q > POS_LIM)  sat_avg = OUT_MAX;
      else                  sat_avg = quo_q[OUT_W-1:0];
    end
  end

  // Pending slot and sticky overrun; a new strobe during a launch from pending just refills the slot.
  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_sum_d = pend_sum_q;
    pend_n_d   = pend_n_q;
    ovr_d      = ovr_q;
    if (launch && pend_vld_q) begin
      pend_vld_d = bus_if.sum_in_valid;
      if (bus_if.sum_in_valid) begin
        pend_sum_d = bus_if.sum_in;
        pend_n_d   = bus_if.n_samples;
      end
    end else if (!launch && bus_if.sum_in_valid) begin
      pend_vld_d = 1'b1;
      pend_sum_d = bus_if.sum_in;
      pend_n_d   = bus_if.n_samples;
    end
    // Set wins over a coincident clear.
    if (!launch && bus_if.sum_in_valid && pend_vld_q) ovr_d = 1'b1;
    else if (bus_if.clear_overrun)                     ovr_d = 1'b0;
  end

  // Divider datapath: capture sign/magnitude/divisor on launch, then one quotient bit per DIV cycle.
  // A zero divisor streams the magnitude straight into the quotient so latency stays uniform.
  always_comb begin
    sign_d = sign_q;
    mag_d  = mag_q;
    div_d  = div_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    rem_sh = (rem_q << 1) | {{SUM_W{1'b0}}, mag_q[SUM_W-1]};
    if (launch) begin
      sign_d = job_sum[SUM_W-1];
      mag_d  = job_sum[SUM_W-1] ? (~job_sum + SUM_W'(1)) : job_sum;
      div_d  = job_n;
      rem_d  = '0;
      quo_d  = '0;
      cnt_d  = '0;
    end else if (state_q == S_DIV) begin
      mag_d = mag_q << 1;
      cnt_d = cnt_q + CNT_W'(1);
      if (div_q == '0) begin
        quo_d = {quo_q[SUM_W-2:0], mag_q[SUM_W-1]};
      end else if (rem_sh >= {1'b0, div_q}) begin
        rem_d = rem_sh - {1'b0, div_q};
        quo_d = {quo_q[SUM_W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh;
        quo_d = {quo_q[SUM_W-2:0], 1'b0};
      end
    end
  end

  // Datapath, pending and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_vld_q <= 1'b0;
      pend_sum_q <= '0;
      pend_n_q   <= '0;
      ovr_q      <= 1'b0;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      div_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      avg_q      <= '0;
      vld_q      <= 1'b0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_sum_q <= pend_sum_d;
      pend_n_q   <= pend_n_d;
      ovr_q      <= ovr_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      div_q      <= div_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      avg_q      <= avg_d;
      vld_q      <= vld_d;
    end
  end

  assign bus_if.avg_out       = avg_q;
  assign bus_if.avg_out_valid = vld_q;
  assign bus_if.busy          = busy_c;
  assign bus_if.overrun       = ovr_q;

endmodule

// File: tb/tb_moving_sum_normalizer.sv
// Bench for moving_sum_normalizer: timeline/queue model plus directed literal cases and random traffic.
// Model predicts avg/strobe/busy/overrun every cycle from arrival times and integer division.
// Inputs change #1 after the falling edge; outputs are compared on the falling edge.
module tb_moving_sum_normalizer;

  localparam int SUM_W = 32;
  localparam int OUT_W = 16;
  localparam int LAT   = SUM_W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  moving_sum_normalizer_if #(.SUM_W(SUM_W), .OUT_W(OUT_W)) bus_if ();

  moving_sum_normalizer #(.SUM_W(SUM_W), .OUT_W(OUT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Truncating average with saturation, straight from integer arithmetic.
  function automatic longint ref_avg(input longint s, input longint n);
    longint mag, q, r;
    mag = (s < 0) ? -s : s;
    q   = (n == 0) ? mag : mag / n;
    r   = (s < 0) ? -q : q;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  int                      m_edge = 0;
  int                      m_launch = 0;
  bit                      m_active = 1'b0;
  logic signed [SUM_W-1:0] m_cur_sum = '0;
  logic        [SUM_W-1:0] m_cur_n = '0;
  bit                      m_pend = 1'b0;
  logic signed [SUM_W-1:0] m_pend_sum = '0;
  logic        [SUM_W-1:0] m_pend_n = '0;
  bit                      m_ovr = 1'b0;
  bit                      m_valid = 1'b0;
  longint                  m_avg = 0;
  bit                      m_v, m_clr, m_fin, m_set;
  logic signed [SUM_W-1:0] m_s;
  logic        [SUM_W-1:0] m_n;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_edge = 0; m_launch = 0; m_active = 0; m_pend = 0;
      m_ovr = 0; m_valid = 0; m_avg = 0;
    end else begin
      m_edge  = m_edge + 1;
      m_v     = bus_if.sum_in_valid;
      m_s     = bus_if.sum_in;
      m_n     = bus_if.n_samples;
      m_clr   = bus_if.clear_overrun;
      m_set   = 0;
      m_valid = 0;
      m_fin   = m_active && (m_edge == m_launch + LAT);
      if (m_fin) begin
        m_valid  = 1;
        m_avg    = ref_avg(longint'(m_cur_sum), longint'(m_cur_n));
        m_active = 0;
      end
      if (!m_active) begin
        if (m_pend) begin
          m_active = 1; m_launch = m_edge; m_cur_sum = m_pend_sum; m_cur_n = m_pend_n;
          m_pend = m_v;
          if (m_v) begin m_pend_sum = m_s; m_pend_n = m_n; end
        end else if (m_v && !m_fin) begin
          m_active = 1; m_launch = m_edge; m_cur_sum = m_s; m_cur_n = m_n;
        end else if (m_v) begin
          m_pend = 1; m_pend_sum = m_s; m_pend_n = m_n;
        end
      end else if (m_v) begin
        if (m_pend) m_set = 1;
        m_pend = 1; m_pend_sum = m_s; m_pend_n = m_n;
      end
      if (m_set)      m_ovr = 1;
      else if (m_clr) m_ovr = 0;
    end
  end

  // Continuous compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("strobe", bus_if.avg_out_valid, m_valid);
      check("avg", longint'(bus_if.avg_out), m_avg);
      check("busy", bus_if.busy, m_active);
      check("overrun", bus_if.overrun, m_ovr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_cycle(input bit v, input logic signed [SUM_W-1:0] s,
                             input logic [SUM_W-1:0] n, input bit clr);
    @(negedge clk);
    #1;
    bus_if.sum_in_valid  = v;
    bus_if.sum_in        = s;
    bus_if.n_samples     = n;
    bus_if.clear_overrun = clr;
  endtask

  // Single job with literal expectation and measured latency.
  task automatic run_job(input string name, input logic signed [SUM_W-1:0] s,
                         input logic [SUM_W-1:0] n, input longint exp);
    int lat;
    bit seen;
    drive_cycle(1'b1, s, n, 1'b0);
    @(posedge clk);
    #1;
    check({name, "_busy"}, bus_if.busy, 1);
    drive_cycle(1'b0, '0, n, 1'b0);
    lat  = 0;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus_if.avg_out_valid) seen = 1;
    end
    check({name, "_latency"}, lat, LAT);
    check({name, "_value"}, longint'(bus_if.avg_out), exp);
  endtask

  logic signed [OUT_W-1:0] got [0:3];
  int got_n;

  task automatic collect(input int want, input int budget);
    got_n = 0;
    for (int i = 0; i < budget && got_n < want; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.avg_out_valid) begin
        got[got_n] = bus_if.avg_out;
        got_n++;
      end
    end
    check("collect_count", got_n, want);
  endtask

  // ---------------- main sequence ----------------
  logic signed [SUM_W-1:0] rs;
  logic        [SUM_W-1:0] rn;

  initial begin
    for (int i = 0; i < 4; i++) got[i] = '0;
    bus_if.sum_in        = '0;
    bus_if.sum_in_valid  = 1'b0;
    bus_if.n_samples     = '0;
    bus_if.clear_overrun = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_en = 1'b1;
    check("rst_avg", longint'(bus_if.avg_out), 0);
    check("rst_strobe", bus_if.avg_out_valid, 0);
    check("rst_busy", bus_if.busy, 0);
    check("rst_overrun", bus_if.overrun, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;

    run_job("exact", 1000, 10, 100);
    run_job("neg_trunc", -1001, 10, -100);
    run_job("odd", 7, 2, 3);
    run_job("sat_pos", 5000000, 1, 32767);
    run_job("bypass_neg", -40000, 0, -32768);
    run_job("min_sum", 32'sh8000_0000, 32'd65536, -32768);
    run_job("bypass_pos", 1234, 0, 1234);

    // Back-to-back: B is overwritten by C.
    fork
      begin
        drive_cycle(1'b1, 100, 1, 1'b0);
        drive_cycle(1'b1, 200, 1, 1'b0);
        drive_cycle(1'b1, 300, 1, 1'b0);
        drive_cycle(1'b0, 0, 1, 1'b0);
      end
      collect(2, 150);
    join
    check("b2b_first", longint'(got[0]), 100);
    check("b2b_second", longint'(got[1]), 300);
    check("b2b_overrun", bus_if.overrun, 1);
    drive_cycle(1'b0, 0, 1, 1'b1);
    drive_cycle(1'b0, 0, 1, 1'b0);
    check("clear_overrun", bus_if.overrun, 0);

    // Strobe landing in the FINISH cycle while pending is full.
    fork
      begin
        drive_cycle(1'b1, 10, 1, 1'b0);
        drive_cycle(1'b1, 50, 1, 1'b0);
        repeat (LAT - 2) drive_cycle(1'b0, 0, 1, 1'b0);
        drive_cycle(1'b1, 60, 1, 1'b0);
        drive_cycle(1'b0, 0, 1, 1'b0);
      end
      collect(3, 200);
    join
    check("fin_first", longint'(got[0]), 10);
    check("fin_second", longint'(got[1]), 50);
    check("fin_third", longint'(got[2]), 60);
    check("fin_overrun", bus_if.overrun, 0);

    // Reset in the middle of a divide.
    drive_cycle(1'b1, 1000, 10, 1'b0);
    repeat (10) drive_cycle(1'b0, 0, 10, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_avg", longint'(bus_if.avg_out), 0);
    check("midrst_busy", bus_if.busy, 0);
    check("midrst_strobe", bus_if.avg_out_valid, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    run_job("post_rst", 64, 8, 8);

    // Random traffic, checked by the model each cycle.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       rs = $urandom;
        1:       rs = $signed($urandom_range(0, 2000)) - 1000;
        2:       rs = 32'sh8000_0000;
        default: rs = $signed($urandom_range(0, 2097152)) - 1048576;
      endcase
      case ($urandom_range(0, 3))
        0:       rn = '0;
        1:       rn = $urandom_range(1, 16);
        2:       rn = $urandom;
        default: rn = $urandom_range(1, 1000);
      endcase
      drive_cycle(($urandom_range(0, 9) == 0), rs, rn, ($urandom_range(0, 39) == 0));
    end
    repeat (2 * LAT + 10) drive_cycle(1'b0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/moving_sum_normalizer.md
Name: moving_sum_normalizer

Overview:
- Downstream stage of the n-sample moving-sum filter. Converts the raw window sum into a true average by dividing it by the integration sample count.
- Division is a sequential radix-2 restoring divide on magnitudes; the sign is reapplied afterwards.
- Output is saturated to the word width and feeds the lock/PID path with an out_valid strobe.
- A one-deep pending register absorbs sums that arrive while a divide is in progress.

Parameters:
- SUM_W, 32: width of the incoming signed sum and of the divisor (config_reg_width).
- OUT_W, 16: width of the signed averaged output (word_width).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- sum_in  in  SUM_W  signed window sum from the moving-sum filter
- sum_in_valid  in  1  single-cycle strobe; sum_in and n_samples are sampled on this edge
- n_samples  in  SUM_W  unsigned divisor (integration sample count); 0 means bypass
- clear_overrun  in  1  synchronous clear of the overrun flag
- avg_out  out  OUT_W  signed average, held between strobes
- avg_out_valid  out  1  one-cycle strobe marking a new avg_out
- busy  out  1  high while in DIV or FINISH
- overrun  out  1  sticky flag: a pending sum was overwritten

Behaviour:
- Reset (asynchronous, rst=0) clears all of the following: avg_out=0, avg_out_valid=0, busy=0, overrun=0, pending empty, state=IDLE, iteration counter=0, and the divider registers. Reset asserted mid-divide aborts the divide with no output strobe.
- States:
  - IDLE: on sum_in_valid (or pending full), capture a job and go to DIV.
    - A job is sign=sum[SUM_W-1], mag=|sum| as unsigned SUM_W, and the divisor n.
    - A captured pending job empties the pending register.
  - DIV: run exactly SUM_W iterations, one quotient bit per clock, MSB first.
    - Each iteration: remainder shifts left with the next mag bit; if remainder ≥ n, subtract n and set the quotient bit.
    - Remainder width is SUM_W+1.
    - After the SUM_W-th iteration, go to FINISH.
  - FINISH: result = sign ? −quotient : quotient, saturated to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
    - avg_out is registered and avg_out_valid=1 for exactly one cycle.
    - Next state is IDLE, or DIV directly if pending is full (pending is captured in this same cycle).
- n=0 bypass: quotient=mag with no divide, but the same latency and state sequence, so latency is uniform.
- Latency: avg_out_valid rises after edge SUM_W+1, counting the sum_in_valid sampling edge as edge 0. That is 33 edges at the default SUM_W.
- Rounding is truncation toward zero (magnitude divide).
- Largest negative sum: −2^(SUM_W−1) has magnitude 2^(SUM_W−1), which fits in unsigned SUM_W bits and must not overflow.
- n_samples is sampled only at capture. Changes during DIV do not affect the job in flight.
- Busy handling:
  - sum_in_valid while busy and pending empty: store into pending.
  - sum_in_valid while pending is full: overwrite pending with the new sum and set overrun=1.
  - sum_in_valid in the FINISH cycle with pending full: the old pending job is captured into DIV and the new sum goes into pending. This is not an overrun.
- sum_in_valid in IDLE with pending empty: capture directly, pending untouched.
- clear_overrun clears the flag. If it coincides with a new overrun event in the same cycle, set wins.
- avg_out holds its last value until the next FINISH.
- busy=1 in DIV and FINISH, 0 in IDLE.

Test Plan:
- Exact divide, default params: sum_in=1000, n=10 → avg_out=100; avg_out_valid one cycle, 33 edges after the sampling edge; busy high throughout.
- Negative truncation: sum_in=−1001, n=10 → avg_out=−100. Also sum_in=7, n=2 → 3.
- Saturation and bypass:
  - sum_in=5,000,000, n=1 → 32767.
  - sum_in=−40000, n=0 → −32768, with the same 33-edge latency.
  - sum_in=−2^31, n=2^16 → −32768.
- Back-to-back: strobes of A=100 (n=1), B=200 one cycle later, C=300 two cycles later → outputs 100 then 300 (B overwritten), overrun=1. A subsequent clear_overrun pulse → overrun=0.
- FINISH-cycle arrival: pending holds 50; a new strobe of 60 lands in the FINISH cycle of the current job → outputs current, 50, 60 in order; overrun stays 0.
- Reset mid-divide: rst low at iteration 10 → all outputs 0, no strobe. After release, a new sum 64, n=8 → avg_out=8 at the normal latency.
